// File: rtl/rst_seq_controller.sv
// Reset sequencer: holds all reset channels low, then releases them one by one,
// with a small register interface for software resets and reset-cause readback.

`ifndef RST_VA_WIDTH
`define RST_VA_WIDTH 8
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module rst_seq_controller #(
   parameter int RST_WIDTH      = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst_ib,
   output logic [RST_WIDTH-1:0]       rst_ob,
   input  logic [`RST_VA_WIDTH-1:0]   addr,
   input  logic                       w_rb,
   input  logic [`BUS_ACC_WIDTH-1:0]  acc,
   output logic [`BUS_WIDTH-1:0]      rdata,
   input  logic [`BUS_WIDTH-1:0]      wdata,
   input  logic                       req,
   output logic                       resp,
   output logic                       fault,
   output logic [1:0]                 fsm_state
);

   localparam int MAXC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0]             HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]             STAG_LAST  = CW'(STAGGER_CYCLES - 1);
   localparam logic [2:0]                LAST_CH    = 3'(RST_WIDTH - 1);
   localparam logic [`BUS_WIDTH-1:0]     WD_ALL     = `BUS_WIDTH'(RST_WIDTH);
   localparam logic [`RST_VA_WIDTH-1:0]  ADDR_RST   = '0;
   localparam logic [`RST_VA_WIDTH-1:0]  ADDR_STAT  = `RST_VA_WIDTH'(1);
   localparam logic [`RST_VA_WIDTH-1:0]  ADDR_CAUSE = `RST_VA_WIDTH'(2);

   localparam logic [1:0] CAUSE_EXT       = 2'd0;
   localparam logic [1:0] CAUSE_SW_ALL    = 2'd1;
   localparam logic [1:0] CAUSE_SW_SINGLE = 2'd2;

   typedef enum logic [1:0] {
      HOLD_ALL = 2'd0,
      STAGGER  = 2'd1,
      RUN      = 2'd2,
      SINGLE   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             k_q, k_d, k_inc;
   logic [RST_WIDTH-1:0]   ob_q, ob_d;
   logic [1:0]             cause_q, cause_d;
   logic [2:0]             cause_ch_q, cause_ch_d;
   logic [1:0]             sync_q;
   logic                   rst_sync;
   logic                   invalid, acc_ok, sw_all, sw_single;
   logic [7:0]             stat_val, cause_val;
   logic [`BUS_WIDTH-1:0]  rd_val, rdata_q;
   logic                   resp_q;

   // Release of rst_ib is synchronized; assertion stays asynchronous.
   always_ff @(posedge clk or negedge rst_ib) begin
      if (!rst_ib) sync_q <= 2'b00;
      else         sync_q <= {sync_q[0], 1'b1};
   end
   assign rst_sync = sync_q[1];

   // Bus handshake: req is a one-cycle strobe; fault answers combinationally in
   // that cycle, and an accepted access gets resp (with rdata) on the next cycle.
   always_comb begin
      invalid = 1'b0;
      if (addr > ADDR_CAUSE)                   invalid = 1'b1;
      if (acc != `BUS_ACC_1B)                  invalid = 1'b1;
      if (w_rb && (addr != ADDR_RST))          invalid = 1'b1;
      if (!w_rb && (addr == ADDR_RST))         invalid = 1'b1;
      if (w_rb && (addr == ADDR_RST) && ((wdata > WD_ALL) || (state_q != RUN)))
         invalid = 1'b1;
   end

   assign fault     = req & invalid;
   assign acc_ok    = req & ~invalid;
   assign sw_all    = acc_ok & w_rb & (wdata == WD_ALL);
   assign sw_single = acc_ok & w_rb & (wdata < WD_ALL);

   always_comb begin
      stat_val = '0;
      for (int i = 0; i < RST_WIDTH; i++) stat_val[i] = ~ob_q[i];
   end
   assign cause_val = {1'b0, cause_ch_q, 2'b00, cause_q};

   always_comb begin
      rd_val = '0;
      if (addr == ADDR_STAT)  rd_val = `BUS_WIDTH'(stat_val);
      if (addr == ADDR_CAUSE) rd_val = `BUS_WIDTH'(cause_val);
   end

   always_ff @(posedge clk or negedge rst_ib) begin
      if (!rst_ib) begin
         resp_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         resp_q  <= acc_ok;
         rdata_q <= (acc_ok && !w_rb) ? rd_val : '0;
      end
   end
   assign resp  = resp_q;
   assign rdata = rdata_q;

   always_ff @(posedge clk or negedge rst_ib) begin
      if (!rst_ib) begin
         state_q    <= HOLD_ALL;
         cnt_q      <= '0;
         k_q        <= '0;
         ob_q       <= '0;
         cause_q    <= CAUSE_EXT;
         cause_ch_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         ob_q       <= ob_d;
         cause_q    <= cause_d;
         cause_ch_q <= cause_ch_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      k_d        = k_q;
      ob_d       = ob_q;
      cause_d    = cause_q;
      cause_ch_d = cause_ch_q;
      k_inc      = k_q + 3'd1;
      case (state_q)
         HOLD_ALL: begin
            if (rst_sync) begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d   = '0;
                  k_d     = '0;
                  ob_d[0] = 1'b1;
                  state_d = (RST_WIDTH == 1) ? RUN : STAGGER;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         STAGGER: begin
            if (cnt_q == STAG_LAST) begin
               cnt_d = '0;
               k_d   = k_inc;
               for (int i = 0; i < RST_WIDTH; i++)
                  if (k_inc == 3'(i)) ob_d[i] = 1'b1;
               if (k_inc == LAST_CH) state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (sw_all) begin
               ob_d    = '0;
               cnt_d   = '0;
               k_d     = '0;
               cause_d = CAUSE_SW_ALL;
               state_d = HOLD_ALL;
            end else if (sw_single) begin
               // k holds the channel being held for the SINGLE phase.
               for (int i = 0; i < RST_WIDTH; i++)
                  if (wdata[2:0] == 3'(i)) ob_d[i] = 1'b0;
               cnt_d      = '0;
               k_d        = wdata[2:0];
               cause_d    = CAUSE_SW_SINGLE;
               cause_ch_d = wdata[2:0];
               state_d    = SINGLE;
            end
         end
         SINGLE: begin
            if (cnt_q == HOLD_LAST) begin
               for (int i = 0; i < RST_WIDTH; i++)
                  if (k_q == 3'(i)) ob_d[i] = 1'b1;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = HOLD_ALL;
      endcase
   end

   assign rst_ob    = ob_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_rst_seq_controller.sv
// Directed bench for rst_seq_controller: power-on staggered release, software
// resets, rejected accesses and an asynchronous reset in the middle of a sequence.

`ifndef RST_VA_WIDTH
`define RST_VA_WIDTH 8
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module tb_rst_seq_controller;

   logic                      clk = 1'b0;
   logic                      rst_ib;
   logic [3:0]                rst_ob;
   logic [`RST_VA_WIDTH-1:0]  addr;
   logic                      w_rb;
   logic [`BUS_ACC_WIDTH-1:0] acc;
   logic [`BUS_WIDTH-1:0]     rdata;
   logic [`BUS_WIDTH-1:0]     wdata;
   logic                      req;
   logic                      resp;
   logic                      fault;
   logic [1:0]                fsm_state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   rst_seq_controller #(
      .RST_WIDTH      (4),
      .HOLD_CYCLES    (16),
      .STAGGER_CYCLES (4)
   ) dut (
      .clk       (clk),
      .rst_ib    (rst_ib),
      .rst_ob    (rst_ob),
      .addr      (addr),
      .w_rb      (w_rb),
      .acc       (acc),
      .rdata     (rdata),
      .wdata     (wdata),
      .req       (req),
      .resp      (resp),
      .fault     (fault),
      .fsm_state (fsm_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   // One bus access; f is sampled in the request cycle, r/rd one cycle later.
   task automatic bus(input logic [7:0] a, input logic w, input logic [1:0] ac,
                      input logic [31:0] wd, output logic f, output logic r,
                      output logic [31:0] rd);
      addr  = a;
      w_rb  = w;
      acc   = ac;
      wdata = wd;
      req   = 1'b1;
      #1 f = fault;
      @(posedge clk);
      #1;
      req   = 1'b0;
      w_rb  = 1'b0;
      addr  = '0;
      acc   = '0;
      wdata = '0;
      r  = resp;
      rd = rdata;
   endtask

   task automatic check_stagger(input string tag, input int t0);
      goto(t0 + 15); chk({tag, " t0+15"}, 32'(rst_ob), 32'h0);
      goto(t0 + 16); chk({tag, " t0+16"}, 32'(rst_ob), 32'h1);
      goto(t0 + 19); chk({tag, " t0+19"}, 32'(rst_ob), 32'h1);
      goto(t0 + 20); chk({tag, " t0+20"}, 32'(rst_ob), 32'h3);
      goto(t0 + 24); chk({tag, " t0+24"}, 32'(rst_ob), 32'h7);
      goto(t0 + 27); chk({tag, " t0+27"}, 32'(rst_ob), 32'h7);
      goto(t0 + 28); chk({tag, " t0+28"}, 32'(rst_ob), 32'hF);
   endtask

   initial begin
      logic        f, r;
      logic [31:0] rd;
      int          t0, e;

      rst_ib = 1'b0;
      req    = 1'b0;
      w_rb   = 1'b0;
      addr   = '0;
      acc    = '0;
      wdata  = '0;

      // reset state
      repeat (4) tick();
      chk("reset rst_ob", 32'(rst_ob), 32'h0);
      chk("reset resp", 32'(resp), 32'h0);
      chk("reset rdata", rdata, 32'h0);

      // power-on: edge A loads sync stage 0, next edge is T0
      rst_ib = 1'b1;
      tick();
      tick();
      t0 = cyc;
      bus(8'd1, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      chk("por stat fault", 32'(f), 32'h0);
      chk("por stat resp", 32'(r), 32'h1);
      chk("por stat rdata", rd, 32'h0F);
      tick();
      chk("idle resp", 32'(resp), 32'h0);
      chk("idle rdata", rdata, 32'h0);
      bus(8'd2, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      chk("por cause", rd, 32'h00);
      check_stagger("por", t0);
      bus(8'd1, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      chk("run stat", rd, 32'h00);

      // software reset-all
      bus(8'd0, 1'b1, `BUS_ACC_1B, 32'd4, f, r, rd);
      e = cyc;
      chk("all fault", 32'(f), 32'h0);
      chk("all resp", 32'(r), 32'h1);
      chk("all rst_ob", 32'(rst_ob), 32'h0);
      bus(8'd2, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      chk("all cause", rd, 32'h01);
      bus(8'd0, 1'b1, `BUS_ACC_1B, 32'd1, f, r, rd);
      chk("hold write fault", 32'(f), 32'h1);
      chk("hold write resp", 32'(r), 32'h0);
      chk("hold write rst_ob", 32'(rst_ob), 32'h0);
      check_stagger("all", e);

      // software single-channel reset of channel 2
      bus(8'd0, 1'b1, `BUS_ACC_1B, 32'd2, f, r, rd);
      e = cyc;
      chk("single fault", 32'(f), 32'h0);
      chk("single resp", 32'(r), 32'h1);
      chk("single rst_ob E", 32'(rst_ob), 32'hB);
      bus(8'd1, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      chk("single stat", rd, 32'h04);
      bus(8'd0, 1'b1, `BUS_ACC_1B, 32'd0, f, r, rd);
      chk("single write fault", 32'(f), 32'h1);
      chk("single write resp", 32'(r), 32'h0);
      goto(e + 15);
      chk("single rst_ob E+15", 32'(rst_ob), 32'hB);
      goto(e + 16);
      chk("single rst_ob E+16", 32'(rst_ob), 32'hF);
      bus(8'd2, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      chk("single cause", rd, 32'h22);

      // rejected accesses
      bus(8'd0, 1'b1, `BUS_ACC_1B, 32'd5, f, r, rd);
      chk("rst=5 fault", 32'(f), 32'h1);
      chk("rst=5 resp", 32'(r), 32'h0);
      bus(8'd1, 1'b0, 2'd1, 32'h0, f, r, rd);
      chk("acc 2B fault", 32'(f), 32'h1);
      chk("acc 2B resp", 32'(r), 32'h0);
      bus(8'd3, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      chk("addr 3 fault", 32'(f), 32'h1);
      chk("addr 3 resp", 32'(r), 32'h0);
      bus(8'd0, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      chk("read rst fault", 32'(f), 32'h1);
      chk("read rst resp", 32'(r), 32'h0);
      bus(8'd1, 1'b1, `BUS_ACC_1B, 32'd0, f, r, rd);
      chk("write stat fault", 32'(f), 32'h1);
      chk("invalid rst_ob", 32'(rst_ob), 32'hF);

      // asynchronous reset during STAGGER after channel 1 released
      bus(8'd0, 1'b1, `BUS_ACC_1B, 32'd4, f, r, rd);
      e = cyc;
      goto(e + 21);
      chk("abort pre rst_ob", 32'(rst_ob), 32'h3);
      rst_ib = 1'b0;
      #1;
      chk("abort async rst_ob", 32'(rst_ob), 32'h0);
      tick();
      rst_ib = 1'b1;
      bus(8'd2, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      t0 = cyc + 1;
      chk("abort cause resp", 32'(r), 32'h1);
      chk("abort cause", rd, 32'h00);
      check_stagger("abort", t0);
      bus(8'd1, 1'b0, `BUS_ACC_1B, 32'h0, f, r, rd);
      chk("final stat", rd, 32'h00);

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rst_seq_controller.md
RST_SEQ_CONTROLLER -- requirements
Module: rst_seq_controller

Interface
REQ-001 SHALL have parameter RST_WIDTH, default 4; number of reset channels, legal 1..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16; reset assertion length in clk cycles, legal >=1.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 4; gap between successive channel releases, legal >=1.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_ib  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rst_ob  output  RST_WIDTH  per-channel reset, active-low.
REQ-007 SHALL have port addr  input  `RST_VA_WIDTH  register address.
REQ-008 SHALL have port w_rb  input  1  1=write, 0=read.
REQ-009 SHALL have port acc  input  `BUS_ACC_WIDTH  access size.
REQ-010 SHALL have port rdata  output  `BUS_WIDTH  read data.
REQ-011 SHALL have port wdata  input  `BUS_WIDTH  write data.
REQ-012 SHALL have port req  input  1  bus request, one cycle per access.
REQ-013 SHALL have port resp  output  1  access completed.
REQ-014 SHALL have port fault  output  1  access rejected.

Function
REQ-015 SHALL decode registers: addr 0 RST (W, 1B); addr 1 STAT (R, 1B; bit i = rst_ob[i] low); addr 2 CAUSE (R, 1B; [1:0] 0=EXT, 1=SW_ALL, 2=SW_SINGLE; [6:4] channel of last SW_SINGLE).
REQ-016 SHALL treat RST write wdata<RST_WIDTH as single-channel reset, wdata==RST_WIDTH as reset-all, wdata>RST_WIDTH as invalid.
REQ-017 SHALL flag invalid: addr>2, acc!=`BUS_ACC_1B, write to STAT/CAUSE, read of RST, RST data>RST_WIDTH, RST write while FSM not RUN.
REQ-018 SHALL drive fault = req & invalid combinationally in the request cycle; invalid accesses cause no state change and no resp.
REQ-019 SHALL register resp one cycle after a valid req; rdata SHALL carry zero-extended register value while resp=1, else 0.
REQ-020 SHALL implement FSM states HOLD_ALL, STAGGER, RUN, SINGLE, with one shared counter of width clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1) and channel index k.
REQ-021 HOLD_ALL: rst_ob all 0; after HOLD_CYCLES cycles -> STAGGER, k=0; rst_ob[0] released on the exit edge.
REQ-022 STAGGER: release rst_ob[k] every STAGGER_CYCLES; released bits stay high; on edge releasing channel RST_WIDTH-1 -> RUN; RST_WIDTH=1 goes HOLD_ALL->RUN directly.
REQ-023 Thus, with T0 = first edge synchronized reset is high (or the accepting edge of a SW reset-all), rst_ob[k] SHALL rise at T0+HOLD_CYCLES+k*STAGGER_CYCLES.
REQ-024 RUN + valid reset-all at edge E: rst_ob<=0, CAUSE=SW_ALL, -> HOLD_ALL with T0=E.
REQ-025 RUN + valid single reset channel i at edge E: rst_ob[i]<=0, others unchanged, CAUSE=SW_SINGLE/i, -> SINGLE; rst_ob[i] rises at E+HOLD_CYCLES, -> RUN on that edge.
REQ-026 Counter SHALL saturate-free reload on each phase entry; no wrap-around state reachable.
REQ-027 STAT/CAUSE reads SHALL be accepted in every FSM state.

Reset
REQ-028 rst_ib low SHALL asynchronously force rst_ob=0, resp=0, FSM=HOLD_ALL, counter=0, k=0, CAUSE=EXT.
REQ-029 rst_ib deassertion SHALL pass a 2-flop synchronizer (async-set-low) before FSM counts; rst_ob stays 0 until synchronized.
REQ-030 rst_ib asserted mid-sequence (any state) SHALL abort it and restart from HOLD_ALL.

Verification
REQ-031 Defaults, rst_ib rises -> rst_ob[0..3] rise at T0+16, +20, +24, +28; STAT reads 0x0F before T0+16, 0x00 after T0+28.
REQ-032 RUN, write RST=2 at edge E -> rst_ob=4'b1011 from E to E+16, then 4'b1111; CAUSE reads 0x22.
REQ-033 RUN, write RST=4 -> all low, staggered release as REQ-031; CAUSE=0x01; RST write during HOLD_ALL -> fault=1, no resp.
REQ-034 Write RST=5, acc=2B, addr=3, read of RST -> fault=1 same cycle, resp stays 0, rst_ob unchanged.
REQ-035 rst_ib pulsed low during STAGGER after rst_ob[1] released -> rst_ob=0 immediately, CAUSE=0x00, full sequence restarts.
